// File: rtl/bank_sector_sram_ctrl.sv
// Bank data-array controller: runs one ISU request (write, read, linefill, write-back)
// against NSEC single-port sector arrays, with hold buffering on the xbar and BIU returns.
module bank_sector_sram_ctrl #(
  parameter int NSEC = 2,
  parameter int DW   = 128,
  parameter int SWAY = 6,
  parameter int IDW  = 8,
  parameter int ROBW = 3,
  parameter int CHW  = 2,
  localparam int SW  = (NSEC > 1) ? $clog2(NSEC) : 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     isu_sc_valid_i,
  output logic                     isu_sc_ready_o,
  input  logic [2:0]               isu_sc_opcode_i,
  input  logic [SWAY+SW-1:0]       isu_sc_set_way_offset_i,
  input  logic [CHW-1:0]           isu_sc_channel_id_i,
  input  logic [ROBW-1:0]          isu_sc_rob_num_i,
  input  logic [IDW-1:0]           isu_sc_wbuffer_id_i,
  input  logic [2*NSEC-1:0]        isu_sc_sector_state_i,
  input  logic [NSEC*DW-1:0]       isu_sc_linefill_data_i,
  output logic                     sc_xbar_valid_o,
  input  logic                     sc_xbar_ready_i,
  output logic [CHW-1:0]           sc_xbar_channel_id_o,
  output logic [ROBW-1:0]          sc_xbar_rob_num_o,
  output logic [DW-1:0]            sc_xbar_data_o,
  output logic                     sc_wbuf_req_valid_o,
  output logic [IDW-1:0]           sc_wbuf_req_wbuffer_id_o,
  input  logic                     sc_wbuf_rtn_valid_i,
  input  logic [DW-1:0]            sc_wbuf_rtn_data_i,
  output logic                     sc_biu_valid_o,
  input  logic                     sc_biu_ready_i,
  output logic [NSEC*DW-1:0]       sc_biu_data_o,
  output logic [NSEC*DW/16-1:0]    sc_biu_strb_o,
  output logic [SWAY-1:0]          sc_biu_set_way_o
);
  localparam int SWP = (SW > 0) ? SW : 1;
  localparam int SBW = DW / 16;
  localparam logic [2:0] OP_WRITE = 3'd0;
  localparam logic [2:0] OP_READ  = 3'd1;
  localparam logic [2:0] OP_LF    = 3'd2;
  localparam logic [2:0] OP_WB    = 3'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_WWAIT, ST_RDATA, ST_HOLD} state_t;
  state_t r_state;

  logic [SWP-1:0]      w_sel;
  logic [SWAY-1:0]     w_idx;
  logic [NSEC-1:0]     w_sel_oh, w_dirty, w_empty, w_we, w_re;
  logic [NSEC*DW-1:0]  w_q, w_dmask, w_bdata, w_cap_data, r_hold;
  logic [NSEC*SBW-1:0] w_strb;
  logic [DW-1:0]       w_xdata, w_q_sel, w_lf_sel;
  logic                w_ready, w_xv, w_bv, w_req, w_cap_en, w_is_wb;

  generate
    if (SW > 0) begin : g_sel
      assign w_sel = isu_sc_set_way_offset_i[SWP-1:0];
    end else begin : g_nosel
      assign w_sel = '0;
    end
  endgenerate

  assign w_idx    = isu_sc_set_way_offset_i[SW +: SWAY];
  assign w_sel_oh = NSEC'(1) << w_sel;
  assign w_q_sel  = w_q[w_sel*DW +: DW];
  assign w_lf_sel = isu_sc_linefill_data_i[w_sel*DW +: DW];
  assign w_is_wb  = (isu_sc_opcode_i == OP_WB);
  // Write-back data: live array output in RDATA, buffered copy while the BIU stalls.
  assign w_bdata  = (r_state == ST_HOLD) ? r_hold : (w_q & w_dmask);

  generate
    for (genvar gi = 0; gi < NSEC; gi++) begin : g_sec
      logic [DW-1:0] r_mem [2**SWAY];
      logic [DW-1:0] r_q;
      logic [DW-1:0] w_wdata;

      assign w_dirty[gi] = (isu_sc_sector_state_i[2*gi +: 2] == 2'b10);
      assign w_empty[gi] = (isu_sc_sector_state_i[2*gi +: 2] == 2'b00);
      assign w_dmask[gi*DW +: DW]  = {DW{w_dirty[gi]}};
      assign w_strb[gi*SBW +: SBW] = {SBW{w_dirty[gi]}};
      assign w_wdata = (r_state == ST_WWAIT) ? sc_wbuf_rtn_data_i
                                             : isu_sc_linefill_data_i[gi*DW +: DW];

      always_ff @(posedge clk_i) begin
        if (w_we[gi]) r_mem[w_idx] <= w_wdata;
        if (w_re[gi]) r_q <= r_mem[w_idx];
      end
      assign w_q[gi*DW +: DW] = r_q;
    end
  endgenerate

  // Everything is gated by reset so no array write lands once reset is raised.
  always_comb begin
    w_ready    = 1'b0;
    w_xv       = 1'b0;
    w_bv       = 1'b0;
    w_req      = 1'b0;
    w_we       = '0;
    w_re       = '0;
    w_xdata    = '0;
    w_cap_en   = 1'b0;
    w_cap_data = '0;
    if (!rst_i) begin
      case (r_state)
        ST_IDLE: begin
          if (isu_sc_valid_i) begin
            case (isu_sc_opcode_i)
              OP_WRITE: w_req = 1'b1;
              OP_READ:  w_re  = w_sel_oh;
              OP_LF: begin
                w_we       = w_sel_oh | w_empty;
                w_xv       = 1'b1;
                w_xdata    = w_lf_sel;
                w_ready    = sc_xbar_ready_i;
                w_cap_en   = 1'b1;
                w_cap_data = (NSEC*DW)'(w_lf_sel);
              end
              OP_WB: begin
                w_re    = w_dirty;
                w_ready = ~|w_dirty;
              end
              default: w_ready = 1'b1;
            endcase
          end
        end
        ST_WWAIT: begin
          if (sc_wbuf_rtn_valid_i) begin
            w_we    = w_sel_oh;
            w_ready = 1'b1;
          end
        end
        ST_RDATA, ST_HOLD: begin
          w_cap_en = (r_state == ST_RDATA);
          if (w_is_wb) begin
            w_bv       = 1'b1;
            w_ready    = sc_biu_ready_i;
            w_cap_data = w_bdata;
          end else begin
            w_xv       = 1'b1;
            w_xdata    = (r_state == ST_RDATA) ? w_q_sel : r_hold[DW-1:0];
            w_ready    = sc_xbar_ready_i;
            w_cap_data = (NSEC*DW)'(w_q_sel);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (isu_sc_valid_i) begin
            case (isu_sc_opcode_i)
              OP_WRITE: r_state <= ST_WWAIT;
              OP_READ:  r_state <= ST_RDATA;
              OP_LF:    if (!sc_xbar_ready_i) r_state <= ST_HOLD;
              OP_WB:    if (|w_dirty) r_state <= ST_RDATA;
              default:  r_state <= ST_IDLE;
            endcase
          end
        end
        ST_WWAIT: if (sc_wbuf_rtn_valid_i) r_state <= ST_IDLE;
        ST_RDATA: r_state <= w_ready ? ST_IDLE : ST_HOLD;
        ST_HOLD:  if (w_ready) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_cap_en) r_hold <= w_cap_data;
  end

  assign isu_sc_ready_o           = w_ready;
  assign sc_xbar_valid_o          = w_xv;
  assign sc_xbar_data_o           = w_xdata;
  assign sc_xbar_channel_id_o     = w_xv ? isu_sc_channel_id_i : '0;
  assign sc_xbar_rob_num_o        = w_xv ? isu_sc_rob_num_i : '0;
  assign sc_wbuf_req_valid_o      = w_req;
  assign sc_wbuf_req_wbuffer_id_o = w_req ? isu_sc_wbuffer_id_i : '0;
  assign sc_biu_valid_o           = w_bv;
  assign sc_biu_data_o            = w_bv ? w_bdata : '0;
  assign sc_biu_strb_o            = w_bv ? w_strb : '0;
  assign sc_biu_set_way_o         = w_bv ? w_idx : '0;
endmodule
